wave_history_writer: RTL and testbench

- Upstream of the VGA display path.
- Decimates the synthesizer's output sample stream and trigger-aligns it on a rising zero crossing.
- Writes one screen-width of 6-bit display amplitudes into the output-history region of the shared display RAM; the VGA side reads that region back by column.
- Re-arms once per displayed frame, so the waveform stays stable on screen.

---
 rtl/wave_history_writer_pkg.sv | 34 +++
 rtl/wave_history_writer_if.sv | 22 ++
 rtl/wave_history_writer_sample_decimator.sv | 41 ++++
 rtl/wave_history_writer.sv | 114 +++++++++++
 tb/tb_wave_history_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_history_writer_pkg.sv
// Shared display-RAM constants, FSM encodings and amplitude helpers for the
// waveform history writer.
package wave_history_writer_pkg;

  localparam logic [7:0] NOTE_ON_START_ADDRESS  = 8'd4;
  localparam logic [7:0] OUT_HIST_START_ADDRESS = 8'd52;

  localparam int AMP_MSB = 28;
  localparam int AMP_LSB = 23;

  localparam logic [1:0] ARMED     = 2'd0;
  localparam logic [1:0] WAIT_TRIG = 2'd1;
  localparam logic [1:0] CAPTURE   = 2'd2;
  localparam logic [1:0] HOLD      = 2'd3;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] din;
  } ramWrite_t;

  // Flipping the sign bit turns the top six two's-complement bits into offset binary.
  function automatic logic [5:0] ampEncode(input logic [5:0] sampleTop);
    return {~sampleTop[5], sampleTop[4:0]};
  endfunction

  function automatic logic [31:0] ramWord(input logic [5:0] amp);
    logic [31:0] word;
    word = '0;
    word[AMP_MSB:AMP_LSB] = amp;
    return word;
  endfunction

endpackage

// File: rtl/wave_history_writer_if.sv
// Sample-stream input and display-RAM write port of the waveform history writer.
interface wave_history_writer_if;

  logic signed [15:0] sample;
  logic               sample_valid;
  logic               frame_done;
  logic               ram_we;
  logic [7:0]         ram_waddr;
  logic [31:0]        ram_din;
  logic               busy;

  modport master (
    output sample, sample_valid, frame_done,
    input  ram_we, ram_waddr, ram_din, busy
  );

  modport slave (
    input  sample, sample_valid, frame_done,
    output ram_we, ram_waddr, ram_din, busy
  );

endinterface

// File: rtl/wave_history_writer_sample_decimator.sv
// Counts sample strobes and fires a decimated event on every DECIMATE-th one,
// passing along the top six bits of that cycle's sample.
module wave_history_writer_sample_decimator #(
  parameter int DECIMATE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_i,
  input  logic        sampleValid_i,
  output logic        decEvent_o,
  output logic [5:0]  decTop_o
);

  localparam int CW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIMATE - 1);

  logic [CW-1:0] count_q, count_d;
  logic          unusedLsbs;

  always_comb begin
    count_d = count_q;
    if (sampleValid_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign decEvent_o = sampleValid_i && (count_q == LAST);
  assign decTop_o   = sample_i[15:10];

  // Display amplitude only needs six bits; the rest of the sample is dropped.
  assign unusedLsbs = ^sample_i[9:0];

endmodule

// File: rtl/wave_history_writer.sv
// Captures one trigger-aligned screen-width of decimated audio into the
// output-history region of the display RAM, re-arming once per frame.
module wave_history_writer
  import wave_history_writer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = OUT_HIST_START_ADDRESS,
  parameter int         HIST_LEN  = 160,
  parameter int         DECIMATE  = 4,
  parameter int         TIMEOUT   = 1024
) (
  input logic                 clk,
  input logic                 reset,
  wave_history_writer_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    COL_LAST = 8'(HIST_LEN - 1);

  logic          decEvent;
  logic [5:0]    decTop;
  logic          trig;
  logic [1:0]    state_q, state_d;
  logic [7:0]    col_q, col_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          prevNeg_q, prevNeg_d;
  ramWrite_t     wr_q, wr_d;

  wave_history_writer_sample_decimator #(
    .DECIMATE(DECIMATE)
  ) u_decimator (
    .clk          (clk),
    .reset        (reset),
    .sample_i     (bus.sample),
    .sampleValid_i(bus.sample_valid),
    .decEvent_o   (decEvent),
    .decTop_o     (decTop)
  );

  assign trig = decEvent && prevNeg_q && !decTop[5];

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    tmo_d     = tmo_q;
    prevNeg_d = prevNeg_q;
    wr_d      = wr_q;
    wr_d.we   = 1'b0;

    if (decEvent) begin
      prevNeg_d = decTop[5];
    end

    case (state_q)
      ARMED: begin
        if (decEvent) begin
          state_d = WAIT_TRIG;
          tmo_d   = '0;
        end
      end
      WAIT_TRIG: begin
        // A forced capture after the timeout keeps the display alive on DC or silence.
        if (decEvent) begin
          if (trig || (tmo_q == TMO_LAST)) begin
            wr_d    = '{we: 1'b1, addr: BASE_ADDR, din: ramWord(ampEncode(decTop))};
            state_d = (HIST_LEN == 1) ? HOLD : CAPTURE;
            col_d   = 8'd1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (decEvent) begin
          wr_d = '{we: 1'b1, addr: BASE_ADDR + col_q, din: ramWord(ampEncode(decTop))};
          if (col_q == COL_LAST) begin
            state_d = HOLD;
            col_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.frame_done) begin
          state_d = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARMED;
      col_q     <= '0;
      tmo_q     <= '0;
      prevNeg_q <= 1'b0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      tmo_q     <= tmo_d;
      prevNeg_q <= prevNeg_d;
      wr_q      <= wr_d;
    end
  end

  assign bus.ram_we    = wr_q.we;
  assign bus.ram_waddr = wr_q.addr;
  assign bus.ram_din   = wr_q.din;
  assign bus.busy      = (state_q == WAIT_TRIG) || (state_q == CAPTURE);

endmodule

// File: tb/tb_wave_history_writer.sv
// Scoreboarded bench: two instances (DECIMATE=1/TIMEOUT=1024 and DECIMATE=4/TIMEOUT=8)
// with expected RAM writes queued as stimulus is driven.
module tb_wave_history_writer;
  import wave_history_writer_pkg::*;

  localparam logic [7:0] BASE = 8'd52;
  localparam int         HLEN = 160;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] din;
    int          due;
  } expWrite_t;

  logic clk = 1'b0;
  logic resetA, resetB;
  int   cycleNo = 0;
  int   assertCount = 0;
  int   failCount = 0;
  expWrite_t qA[$];
  expWrite_t qB[$];

  wave_history_writer_if busA();
  wave_history_writer_if busB();

  wave_history_writer #(.BASE_ADDR(BASE), .HIST_LEN(HLEN), .DECIMATE(1), .TIMEOUT(1024))
    dutA (.clk(clk), .reset(resetA), .bus(busA));

  wave_history_writer #(.BASE_ADDR(BASE), .HIST_LEN(HLEN), .DECIMATE(4), .TIMEOUT(8))
    dutB (.clk(clk), .reset(resetB), .bus(busB));

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Offset-binary amplitude is the sample shifted into unsigned range, top six bits.
  function automatic logic [31:0] expDin(input logic [15:0] s);
    int a;
    a = (int'($signed(s)) + 32768) >>> 10;
    return 32'(a) << 23;
  endfunction

  always begin : monitorA
    expWrite_t e;
    @(posedge clk);
    #1;
    if (busA.ram_we === 1'b1) begin
      assertCount++;
      if (qA.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpectedWriteA: got addr=%0d din=%h, expected no write", busA.ram_waddr, busA.ram_din);
      end else begin
        e = qA.pop_front();
        if (busA.ram_waddr !== e.addr || busA.ram_din !== e.din || cycleNo != e.due) begin
          failCount++;
          $display("[TB] FAIL writeA: got addr=%0d din=%h cycle=%0d, expected addr=%0d din=%h cycle=%0d",
                   busA.ram_waddr, busA.ram_din, cycleNo, e.addr, e.din, e.due);
        end
      end
    end else if (qA.size() > 0 && qA[0].due <= cycleNo) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL missingWriteA: got no write, expected addr=%0d din=%h at cycle %0d", qA[0].addr, qA[0].din, qA[0].due);
      void'(qA.pop_front());
    end
  end

  always begin : monitorB
    expWrite_t e;
    @(posedge clk);
    #1;
    if (busB.ram_we === 1'b1) begin
      assertCount++;
      if (qB.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpectedWriteB: got addr=%0d din=%h, expected no write", busB.ram_waddr, busB.ram_din);
      end else begin
        e = qB.pop_front();
        if (busB.ram_waddr !== e.addr || busB.ram_din !== e.din || cycleNo != e.due) begin
          failCount++;
          $display("[TB] FAIL writeB: got addr=%0d din=%h cycle=%0d, expected addr=%0d din=%h cycle=%0d",
                   busB.ram_waddr, busB.ram_din, cycleNo, e.addr, e.din, e.due);
        end
      end
    end else if (qB.size() > 0 && qB[0].due <= cycleNo) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL missingWriteB: got no write, expected addr=%0d din=%h at cycle %0d", qB[0].addr, qB[0].din, qB[0].due);
      void'(qB.pop_front());
    end
  end

  task automatic stepA(input logic v, input logic [15:0] s, input logic fd, input logic expW, input logic [7:0] col);
    @(negedge clk);
    busA.sample_valid = v;
    busA.sample       = s;
    busA.frame_done   = fd;
    if (expW) qA.push_back(expWrite_t'{addr: BASE + col, din: expDin(s), due: cycleNo + 1});
  endtask

  task automatic stepB(input logic v, input logic [15:0] s, input logic expW, input logic [7:0] col);
    @(negedge clk);
    busB.sample_valid = v;
    busB.sample       = s;
    busB.frame_done   = 1'b0;
    if (expW) qB.push_back(expWrite_t'{addr: BASE + col, din: expDin(s), due: cycleNo + 1});
  endtask

  task automatic pulseResetA();
    @(negedge clk);
    resetA = 1'b1;
    busA.sample_valid = 1'b0;
    busA.frame_done   = 1'b0;
    @(negedge clk);
    resetA = 1'b0;
  endtask

  task automatic pulseResetB();
    @(negedge clk);
    resetB = 1'b1;
    busB.sample_valid = 1'b0;
    busB.frame_done   = 1'b0;
    @(negedge clk);
    resetB = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    assertCount++;
    if ({busA.ram_we, busA.ram_waddr, busA.ram_din, busA.busy} !== 42'd0) begin
      failCount++;
      $display("[TB] FAIL resetOutputsA: got we=%b addr=%0d din=%h busy=%b, expected all 0", busA.ram_we, busA.ram_waddr, busA.ram_din, busA.busy);
    end
    assertCount++;
    if ({busB.ram_we, busB.ram_waddr, busB.ram_din, busB.busy} !== 42'd0) begin
      failCount++;
      $display("[TB] FAIL resetOutputsB: got we=%b addr=%0d din=%h busy=%b, expected all 0", busB.ram_we, busB.ram_waddr, busB.ram_din, busB.busy);
    end
    assertCount++;
    if (dutA.state_q !== ARMED) begin
      failCount++;
      $display("[TB] FAIL resetStateA: got %0d, expected %0d", dutA.state_q, ARMED);
    end
    resetA = 1'b0;
    resetB = 1'b0;
  endtask

  // Ramp from -100: first strobe arms, sample 0 (after -1) triggers, writes 0..159.
  task automatic test_ramp_capture();
    pulseResetA();
    for (int i = 0; i < 300; i++) begin
      stepA(1'b1, 16'(-100 + i), 1'b0, (i >= 100 && i < 100 + HLEN), 8'(i - 100));
      if (i == 150) begin
        assertCount++;
        if (busA.busy !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL busyDuringCapture: got %b, expected 1", busA.busy);
        end
      end
      if (i == 100 + HLEN - 1) begin
        @(posedge clk);
        #1;
        assertCount++;
        if (busA.busy !== 1'b0 || busA.ram_we !== 1'b1 || busA.ram_waddr !== 8'd211) begin
          failCount++;
          $display("[TB] FAIL busyFallsOnLastWrite: got busy=%b we=%b addr=%0d, expected busy=0 we=1 addr=211",
                   busA.busy, busA.ram_we, busA.ram_waddr);
        end
      end
    end
    repeat (4) stepA(1'b0, 16'd0, 1'b0, 1'b0, 8'd0);
    assertCount++;
    if (qA.size() != 0 || busA.busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rampComplete: got pending=%0d busy=%b, expected 0 and 0", qA.size(), busA.busy);
    end
  endtask

  // Slow sine crossing zero once; strobes every 3 cycles, events on every 4th strobe.
  task automatic test_decimated_sine();
    int  smp[700];
    int  trigK;
    bit  prevNeg;
    real r;
    pulseResetB();
    for (int k = 0; k < 700; k++) begin
      r = 20000.0 * $sin(2.0 * 3.14159265 * real'(k - 20) / 2000.0);
      smp[k] = $rtoi(r);
    end
    trigK   = -1;
    prevNeg = (smp[3] < 0);
    for (int k = 7; k < 700; k += 4) begin
      if (prevNeg && smp[k] >= 0) begin
        trigK = k;
        break;
      end
      prevNeg = (smp[k] < 0);
    end
    for (int k = 0; k < 700; k++) begin
      stepB(1'b1, 16'(smp[k]),
            (trigK >= 0 && k >= trigK && (k - trigK) % 4 == 0 && (k - trigK) / 4 < HLEN),
            8'((k - trigK) / 4));
      if (k == trigK) begin
        @(posedge clk);
        #1;
        assertCount++;
        if (busB.ram_we !== 1'b1 || busB.ram_waddr !== BASE) begin
          failCount++;
          $display("[TB] FAIL sineColumn0: got we=%b addr=%0d, expected we=1 addr=%0d", busB.ram_we, busB.ram_waddr, BASE);
        end
      end
      stepB(1'b0, 16'(smp[k]), 1'b0, 8'd0);
      stepB(1'b0, 16'(smp[k]), 1'b0, 8'd0);
    end
    assertCount++;
    if (qB.size() != 0 || busB.busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL sineComplete: got pending=%0d busy=%b, expected 0 and 0", qB.size(), busB.busy);
    end
  endtask

  // Constant -1 never triggers; with the arming event counted, the 9th event forces column 0.
  task automatic test_forced_capture();
    pulseResetB();
    for (int k = 0; k < 700; k++) begin
      stepB(1'b1, 16'hFFFF, (k >= 35 && (k - 35) % 4 == 0 && (k - 35) / 4 < HLEN), 8'((k - 35) / 4));
      if (k == 35) begin
        @(posedge clk);
        #1;
        assertCount++;
        if (busB.ram_we !== 1'b1 || busB.ram_din !== 32'h0F800000 || busB.ram_waddr !== BASE) begin
          failCount++;
          $display("[TB] FAIL forcedColumn0: got we=%b addr=%0d din=%h, expected we=1 addr=52 din=0f800000",
                   busB.ram_we, busB.ram_waddr, busB.ram_din);
        end
      end
    end
    stepB(1'b0, 16'd0, 1'b0, 8'd0);
    assertCount++;
    if (qB.size() != 0) begin
      failCount++;
      $display("[TB] FAIL forcedComplete: got pending=%0d, expected 0", qB.size());
    end
  endtask

  task automatic test_frame_done();
    pulseResetA();
    stepA(1'b1, 16'(-2000), 1'b0, 1'b0, 8'd0);
    stepA(1'b1, 16'(-1000), 1'b0, 1'b0, 8'd0);
    for (int c = 0; c < HLEN; c++) begin
      stepA(1'b1, 16'(c * 200), (c == 80), 1'b1, 8'(c));
      if (c == 81) begin
        assertCount++;
        if (busA.busy !== 1'b1 || dutA.state_q !== CAPTURE) begin
          failCount++;
          $display("[TB] FAIL frameDoneIgnored: got busy=%b state=%0d, expected busy=1 state=%0d", busA.busy, dutA.state_q, CAPTURE);
        end
      end
    end
    repeat (5) stepA(1'b0, 16'd0, 1'b0, 1'b0, 8'd0);
    assertCount++;
    if (dutA.state_q !== HOLD || qA.size() != 0) begin
      failCount++;
      $display("[TB] FAIL holdReached: got state=%0d pending=%0d, expected state=%0d pending=0", dutA.state_q, qA.size(), HOLD);
    end
    // The strobe coinciding with frame_done must not arm; had it armed, 7000 would trigger.
    stepA(1'b1, 16'(-5000), 1'b1, 1'b0, 8'd0);
    stepA(1'b1, 16'(7000), 1'b0, 1'b0, 8'd0);
    assertCount++;
    if (dutA.state_q !== ARMED) begin
      failCount++;
      $display("[TB] FAIL rearmed: got state=%0d, expected %0d", dutA.state_q, ARMED);
    end
    stepA(1'b1, 16'(-3000), 1'b0, 1'b0, 8'd0);
    for (int c = 0; c < HLEN; c++) begin
      stepA(1'b1, 16'(c * 200), 1'b0, 1'b1, 8'(c));
    end
    repeat (3) stepA(1'b0, 16'd0, 1'b0, 1'b0, 8'd0);
    assertCount++;
    if (qA.size() != 0) begin
      failCount++;
      $display("[TB] FAIL secondCapture: got pending=%0d, expected 0", qA.size());
    end
  endtask

  task automatic test_reset_mid_capture();
    pulseResetA();
    stepA(1'b1, 16'(-2000), 1'b0, 1'b0, 8'd0);
    stepA(1'b1, 16'(-1000), 1'b0, 1'b0, 8'd0);
    for (int c = 0; c < 50; c++) begin
      stepA(1'b1, 16'(c * 200), 1'b0, 1'b1, 8'(c));
    end
    @(negedge clk);
    resetA = 1'b1;
    busA.sample_valid = 1'b1;
    busA.sample       = 16'(50 * 200);
    @(posedge clk);
    #1;
    assertCount++;
    if (busA.ram_we !== 1'b0 || busA.busy !== 1'b0 || dutA.state_q !== ARMED) begin
      failCount++;
      $display("[TB] FAIL resetMidCapture: got we=%b busy=%b state=%0d, expected 0 0 %0d", busA.ram_we, busA.busy, dutA.state_q, ARMED);
    end
    @(negedge clk);
    resetA = 1'b0;
    busA.sample_valid = 1'b0;
    stepA(1'b1, 16'(-2000), 1'b0, 1'b0, 8'd0);
    stepA(1'b1, 16'(-1000), 1'b0, 1'b0, 8'd0);
    for (int c = 0; c < HLEN; c++) begin
      stepA(1'b1, 16'(c * 200), 1'b0, 1'b1, 8'(c));
    end
    repeat (3) stepA(1'b0, 16'd0, 1'b0, 1'b0, 8'd0);
    assertCount++;
    if (qA.size() != 0) begin
      failCount++;
      $display("[TB] FAIL captureAfterReset: got pending=%0d, expected 0", qA.size());
    end
  endtask

  task automatic test_extremes();
    logic [15:0] s;
    pulseResetA();
    stepA(1'b1, 16'(-2000), 1'b0, 1'b0, 8'd0);
    stepA(1'b1, 16'(-1000), 1'b0, 1'b0, 8'd0);
    for (int c = 0; c < HLEN; c++) begin
      s = (c == 0) ? 16'h0000 : ((c % 2 == 1) ? 16'h7FFF : 16'h8000);
      stepA(1'b1, s, 1'b0, 1'b1, 8'(c));
      if (c == 1 || c == 2) begin
        @(posedge clk);
        #1;
        assertCount++;
        if (busA.ram_din !== ((c == 1) ? 32'h1F800000 : 32'h00000000)) begin
          failCount++;
          $display("[TB] FAIL extremeAmp col%0d: got din=%h, expected %h", c, busA.ram_din, (c == 1) ? 32'h1F800000 : 32'h00000000);
        end
      end
    end
    repeat (3) stepA(1'b0, 16'd0, 1'b0, 1'b0, 8'd0);
    assertCount++;
    if (qA.size() != 0) begin
      failCount++;
      $display("[TB] FAIL extremesComplete: got pending=%0d, expected 0", qA.size());
    end
  endtask

  initial begin
    resetA = 1'b1;
    resetB = 1'b1;
    busA.sample = '0; busA.sample_valid = 1'b0; busA.frame_done = 1'b0;
    busB.sample = '0; busB.sample_valid = 1'b0; busB.frame_done = 1'b0;
    test_reset();
    test_ramp_capture();
    test_decimated_sine();
    test_forced_capture();
    test_frame_done();
    test_reset_mid_capture();
    test_extremes();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
